i_cache_assoc: RTL and testbench
================================

I_CACHE_ASSOC -- requirements
Module: i_cache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning associativity; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter SETS, default 8, meaning sets per way; it SHALL be a power of two, at least 2.
REQ-003 SHALL have parameter LINE_BITS, default 256, meaning line width; it SHALL be a power of two, at least 64.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (the name is kept; the polarity is high).
REQ-006 SHALL have port cache_read, input, 1 bit: fetch request, held high until hit.
REQ-007 SHALL have port addr, input, 32 bits: byte address, held stable while cache_read=1.
REQ-008 SHALL have port flush, input, 1 bit: single-cycle pulse that invalidates all lines (fence.i).
REQ-009 SHALL have port mmem_r, output, 1 bit: main-memory line read request.
REQ-010 SHALL have port mmem_addr, output, 32 bits: line-aligned fetch address.
REQ-011 SHALL have port mmem_status, input, 1 bit: line-read complete; mmem_out is valid in that cycle.
REQ-012 SHALL have port mmem_out, input, LINE_BITS bits: returned line.
REQ-013 SHALL have port cache_out, output, 32 bits: selected instruction word.
REQ-014 SHALL have port hit, output, 1 bit: cache_out is valid for the current addr.

Function
REQ-015 addr SHALL split into offset (low log2(LINE_BITS/8) bits), then index (log2(SETS) bits), then tag (the remaining high bits); addr[1:0] SHALL be ignored.
REQ-016 Lookup SHALL be combinational: hit = cache_read & (state==IDLE) & (some valid way has a matching tag); zero-cycle latency.
REQ-017 On hit, cache_out SHALL be the 32-bit word at addr[offset-1:2] of the matching line; when hit=0, cache_out SHALL be 0.
REQ-018 At most one way per set SHALL ever match; there SHALL be no duplicate fills.
REQ-019 The FSM SHALL have states IDLE and FETCH.
REQ-020 In IDLE with cache_read=1 and no hit, the next state SHALL be FETCH, and the block SHALL latch the index, tag and victim way.
REQ-021 In FETCH, mmem_r SHALL be 1 and mmem_addr SHALL be {latched tag, latched index, zero offset}; in IDLE, mmem_r SHALL be 0 and mmem_addr SHALL be 0.
REQ-022 In FETCH, on a clock edge where mmem_status=1, the block SHALL write mmem_out and the tag into the victim way, set its valid bit, mark it most-recently-used, and return to IDLE.
REQ-023 The minimum miss penalty SHALL be: miss at cycle T, mmem_r high from T+1, hit no earlier than the cycle after the status edge.
REQ-024 Victim selection SHALL pick the lowest-numbered invalid way if any exists; otherwise it SHALL pick the tree-PLRU way (WAYS-1 bits per set; WAYS=1 means always way 0).
REQ-025 Each hit SHALL update the set's PLRU bits to mark the hit way most-recently-used on that clock edge.
REQ-026 If cache_read drops during FETCH, the fill SHALL still complete.
REQ-027 Flush in IDLE SHALL clear all valid bits at that edge; hit SHALL be 0 in the flush cycle.
REQ-028 Flush during FETCH SHALL be latched as pending; after the fill, the return to IDLE SHALL clear all valid bits, including the just-filled line.
REQ-029 Flush coincident with the fill edge SHALL behave per REQ-028.
REQ-030 PLRU bits SHALL NOT be cleared by flush.

Reset
REQ-031 While rst_n=1 at a clock edge, the block SHALL clear state (to IDLE), all valid bits, all PLRU bits, the pending flush and all latched fields.
REQ-032 After reset, mmem_r, mmem_addr, hit and cache_out SHALL all be 0.
REQ-033 Reset during FETCH SHALL abandon the fetch: mmem_r SHALL be 0 in the following cycle, and any later mmem_status SHALL be ignored while in IDLE.
REQ-034 The data and tag arrays SHALL NOT require reset.

Structure
REQ-035 Package icache_pkg SHALL hold the state enum (IDLE, FETCH) and the width-derivation constants/functions (offset, index and tag widths).
REQ-036 Sub-module plru_tree (parameter WAYS) SHALL provide victim-way computation and the update-on-access function per set.
REQ-037 Arrays SHALL be flop-based, with one write port per way.

Verification (WAYS=2, SETS=8, LINE_BITS=256)
REQ-038 Cold miss: after reset, read 0x00000004 -> mmem_r=1 with mmem_addr=0x00000000 next cycle; after mmem_status, hit=1 and cache_out = word 1 of the line.
REQ-039 Second way: read 0x00000100 (index 0, new tag) -> miss, fills way 1; then 0x00000004 and 0x00000100 each hit in 0 cycles.
REQ-040 PLRU eviction: hit 0x00000004, then read 0x00000200 -> evicts the 0x00000100 line; re-reading 0x00000100 misses while 0x00000004 hits.
REQ-041 Flush in IDLE: pulse flush, then read 0x00000004 -> miss with mmem_r=1.
REQ-042 Flush during FETCH: pulse flush while mmem_r=1 -> fill completes, the retry of the same address misses again.
REQ-043 Reset mid-FETCH: assert rst_n for 1 cycle while in FETCH -> mmem_r=0 the next cycle; all previous addresses miss.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icache_pkg;

   // Controller states: IDLE serves lookups, FETCH waits for a line from main memory.
   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   // Byte-offset width inside one line.
   function automatic int offset_w(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

   // Set-index width.
   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   // Tag width: whatever remains of the 32-bit address above index and offset.
   function automatic int tag_w(input int sets, input int line_bits);
      return 32 - offset_w(line_bits) - index_w(sets);
   endfunction

   // Width of a way number; kept at least 1 so direct-mapped builds still elaborate.
   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   // Tree-PLRU state bits per set (WAYS-1), kept at least 1 for the same reason.
   function automatic int plru_w(input int ways);
      return (ways > 1) ? ways - 1 : 1;
   endfunction

endpackage

// File: rtl/i_cache_assoc_plru_tree.sv
// Tree pseudo-LRU for one set: victim choice and update-on-access.
// Latency: purely combinational.
// Backpressure: none.
// Ports: bits_in    - current PLRU bits of the set
//        access_way - way being touched (hit or fill)
//        victim     - way the tree points at as least recently used
//        bits_upd   - PLRU bits after marking access_way most recently used
module plru_tree
   import icache_pkg::*;
#(
   parameter int WAYS = 2
) (
   input  logic [plru_w(WAYS)-1:0] bits_in,
   input  logic [way_w(WAYS)-1:0]  access_way,
   output logic [way_w(WAYS)-1:0]  victim,
   output logic [plru_w(WAYS)-1:0] bits_upd
);

   // Each node bit points toward the less recently used subtree (0 = lower half).
   generate
      if (WAYS == 4) begin : g_w4
         // bit0 = root, bit1 = node over ways 0/1, bit2 = node over ways 2/3
         always_comb begin
            victim   = bits_in[0] ? {1'b1, bits_in[2]} : {1'b0, bits_in[1]};
            bits_upd = bits_in;
            bits_upd[0] = ~access_way[1];
            if (access_way[1]) begin
               bits_upd[2] = ~access_way[0];
            end else begin
               bits_upd[1] = ~access_way[0];
            end
         end
      end else if (WAYS == 2) begin : g_w2
         always_comb begin
            victim   = bits_in;
            bits_upd = ~access_way;
         end
      end else begin : g_w1
         logic unused_access;
         assign unused_access = ^access_way;
         assign victim        = '0;
         assign bits_upd      = bits_in;
      end
   endgenerate

endmodule

// File: rtl/i_cache_assoc.sv
// Set-associative read-only instruction cache with tree-PLRU replacement and fence.i flush.
// Latency: hit is combinational (same cycle); a miss costs one cycle to FETCH plus the memory time.
// Backpressure: requester holds cache_read/addr until hit; memory side completes with mmem_status.
// Ports: clk, rst_n (sync, active-high reset)
//        cache_read/addr/flush          - fetch request, byte address, invalidate-all pulse
//        mmem_r/mmem_addr               - line read request to main memory
//        mmem_status/mmem_out           - line returned by main memory
//        cache_out/hit                  - selected instruction word and its valid flag
module i_cache_assoc
   import icache_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int SETS      = 8,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cache_read,
   input  logic [31:0]          addr,
   input  logic                 flush,
   output logic                 mmem_r,
   output logic [31:0]          mmem_addr,
   input  logic                 mmem_status,
   input  logic [LINE_BITS-1:0] mmem_out,
   output logic [31:0]          cache_out,
   output logic                 hit
);

   localparam int OFF_W  = offset_w(LINE_BITS);
   localparam int IDX_W  = index_w(SETS);
   localparam int TAG_W  = tag_w(SETS, LINE_BITS);
   localparam int WW     = way_w(WAYS);
   localparam int PW     = plru_w(WAYS);
   localparam int WSEL_W = OFF_W - 2;

   // ---------------- address split ----------------
   logic [IDX_W-1:0]  a_idx;
   logic [TAG_W-1:0]  a_tag;
   logic [WSEL_W-1:0] a_word;
   logic              unused_addr_lsb;

   assign a_idx  = addr[OFF_W +: IDX_W];
   assign a_tag  = addr[31 -: TAG_W];
   assign a_word = addr[2 +: WSEL_W];
   // Instruction fetch is word granular; the byte lane bits carry no information.
   assign unused_addr_lsb = ^addr[1:0];

   // ---------------- state ----------------
   state_t                     state_q, state_d;
   logic [WAYS-1:0][SETS-1:0]  valid_q, valid_d;
   logic [PW-1:0]              plru_q [SETS];
   logic [PW-1:0]              plru_d [SETS];
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [TAG_W-1:0]           tag_q, tag_d;
   logic [WW-1:0]              victim_q, victim_d;
   logic                       flush_pend_q, flush_pend_d;

   logic [WAYS-1:0]            fill_we;
   logic [TAG_W-1:0]           rd_tag  [WAYS];
   logic [LINE_BITS-1:0]       rd_line [WAYS];

   // ---------------- tag/data arrays: one write port per way ----------------
   // Contents are qualified by valid_q, so these flops carry no reset.
   generate
      for (genvar w = 0; w < WAYS; w++) begin : g_way
         logic [TAG_W-1:0]     tag_mem  [SETS];
         logic [LINE_BITS-1:0] data_mem [SETS];

         always_ff @(posedge clk) begin
            if (fill_we[w]) begin
               tag_mem[idx_q]  <= tag_q;
               data_mem[idx_q] <= mmem_out;
            end
         end

         assign rd_tag[w]  = tag_mem[a_idx];
         assign rd_line[w] = data_mem[a_idx];
      end
   endgenerate

   // ---------------- lookup ----------------
   logic [WAYS-1:0]      match;
   logic                 any_match;
   logic [WW-1:0]        hit_way;
   logic [LINE_BITS-1:0] hit_line;

   always_comb begin
      match    = '0;
      hit_way  = '0;
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = valid_q[w][a_idx] && (rd_tag[w] == a_tag);
         // Fills never duplicate a tag within a set, so OR-merging is a clean mux.
         if (match[w]) begin
            hit_way  = WW'(w);
            hit_line = hit_line | rd_line[w];
         end
      end
   end

   assign any_match = |match;
   // A flush cycle never reports a hit: the line is being invalidated at this edge.
   assign hit       = cache_read && (state_q == IDLE) && any_match && !flush;
   assign cache_out = hit ? hit_line[{a_word, 5'b00000} +: 32] : 32'd0;

   // ---------------- victim selection ----------------
   logic          inv_found;
   logic [WW-1:0] inv_way;
   logic [WW-1:0] plru_victim;
   logic [WW-1:0] new_victim;

   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      // Walk downward so the lowest-numbered invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][a_idx]) begin
            inv_found = 1'b1;
            inv_way   = WW'(w);
         end
      end
   end

   assign new_victim = inv_found ? inv_way : plru_victim;

   // One PLRU evaluator is enough: hits only update in IDLE, fills only in FETCH.
   logic [IDX_W-1:0] plru_idx;
   logic [WW-1:0]    plru_way;
   logic [PW-1:0]    plru_upd;

   assign plru_idx = (state_q == FETCH) ? idx_q    : a_idx;
   assign plru_way = (state_q == FETCH) ? victim_q : hit_way;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits_in    (plru_q[plru_idx]),
      .access_way (plru_way),
      .victim     (plru_victim),
      .bits_upd   (plru_upd)
   );

   // ---------------- next state / outputs ----------------
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      plru_d       = plru_q;
      idx_d        = idx_q;
      tag_d        = tag_q;
      victim_d     = victim_q;
      flush_pend_d = flush_pend_q;
      fill_we      = '0;
      mmem_r       = 1'b0;
      mmem_addr    = 32'd0;

      case (state_q)
         IDLE: begin
            if (flush) begin
               // Invalidate now; a pending request simply misses next cycle.
               valid_d = '0;
            end else if (hit) begin
               plru_d[a_idx] = plru_upd;
            end else if (cache_read && !any_match) begin
               state_d  = FETCH;
               idx_d    = a_idx;
               tag_d    = a_tag;
               victim_d = new_victim;
            end
         end

         FETCH: begin
            mmem_r    = 1'b1;
            mmem_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
            if (flush) begin
               flush_pend_d = 1'b1;
            end
            // The fill completes even if the requester has dropped cache_read.
            if (mmem_status) begin
               for (int w = 0; w < WAYS; w++) begin
                  fill_we[w] = (victim_q == WW'(w));
                  if (victim_q == WW'(w)) begin
                     valid_d[w][idx_q] = 1'b1;
                  end
               end
               plru_d[idx_q] = plru_upd;
               state_d       = IDLE;
               // A flush seen during the fetch (or on this very edge) also kills the new line.
               if (flush_pend_q || flush) begin
                  valid_d      = '0;
                  flush_pend_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
         end
         idx_q        <= '0;
         tag_q        <= '0;
         victim_q     <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         plru_q       <= plru_d;
         idx_q        <= idx_d;
         tag_q        <= tag_d;
         victim_q     <= victim_d;
         flush_pend_q <= flush_pend_d;
      end
   end

endmodule

// File: tb/tb_i_cache_assoc.sv
// Randomised scoreboard bench for i_cache_assoc (2 ways, 8 sets, 256-bit lines).
// Latency: n/a.
// Backpressure: memory responder answers each line read after a random 0-3 cycle delay.
module tb_i_cache_assoc;

   logic         clk;
   logic         rst_n;
   logic         cache_read;
   logic [31:0]  addr;
   logic         flush;
   logic         mmem_r;
   logic [31:0]  mmem_addr;
   logic         mmem_status;
   logic [255:0] mmem_out;
   logic [31:0]  cache_out;
   logic         hit;

   i_cache_assoc #(.WAYS(2), .SETS(8), .LINE_BITS(256)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cache_read  (cache_read),
      .addr        (addr),
      .flush       (flush),
      .mmem_r      (mmem_r),
      .mmem_addr   (mmem_addr),
      .mmem_status (mmem_status),
      .mmem_out    (mmem_out),
      .cache_out   (cache_out),
      .hit         (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model (fully associative view per set, true LRU for 2 ways) ----------------
   bit          m_valid [8][2];
   logic [31:0] m_line  [8][2];
   int          m_mru   [8];

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return a & 32'hFFFF_FFE0;
   endfunction

   function automatic int set_of(input logic [31:0] a);
      return int'((a >> 5) & 32'd7);
   endfunction

   // Memory contents: every word is a fixed hash of its line address and word number.
   function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
      return line ^ (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [255:0] make_line(input logic [31:0] line);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word(line, k);
      return l;
   endfunction

   function automatic int m_lookup(input logic [31:0] a);
      int s = set_of(a);
      for (int w = 0; w < 2; w++)
         if (m_valid[s][w] && m_line[s][w] == line_of(a)) return w;
      return -1;
   endfunction

   task automatic m_fill(input logic [31:0] a);
      int s = set_of(a);
      int v;
      if (!m_valid[s][0])      v = 0;
      else if (!m_valid[s][1]) v = 1;
      else                     v = 1 - m_mru[s];
      m_valid[s][v] = 1'b1;
      m_line[s][v]  = line_of(a);
      m_mru[s]      = v;
   endtask

   task automatic m_clear();
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
   endtask

   task automatic m_reset();
      m_clear();
      for (int s = 0; s < 8; s++) m_mru[s] = 1;
   endtask

   // ---------------- scoreboard queues ----------------
   typedef struct {
      logic [31:0] word;
      bit          miss;
   } exp_t;

   exp_t        exp_q   [$];
   logic [31:0] fetch_q [$];
   bit          resp_hold;
   bit          fetch_seen;

   function automatic exp_t make_exp(input logic [31:0] a, input bit miss);
      exp_t e;
      e.word = mem_word(line_of(a), int'((a >> 2) & 32'd7));
      e.miss = miss;
      return e;
   endfunction

   // Monitor: pops one expectation per presented hit.
   always @(negedge clk) begin
      if (rst_n == 1'b0) begin
         if (!cache_read) fetch_seen = 1'b0;
         else if (mmem_r) fetch_seen = 1'b1;
         if (hit) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_hit", 32'(hit), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("cache_out", cache_out, e.word);
               chk("miss_class", 32'(fetch_seen), 32'(e.miss));
            end
         end else begin
            chk("out_zero_nohit", cache_out, 32'd0);
         end
      end
   end

   // Memory responder.
   always begin
      @(negedge clk);
      if (mmem_r && !resp_hold && rst_n == 1'b0) begin
         if (fetch_q.size() == 0) begin
            n_total++;
            $display("FAIL fetch_unexpected: mmem_addr=%h with no fetch expected", mmem_addr);
         end else begin
            chk("mmem_addr", mmem_addr, fetch_q.pop_front());
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         mmem_status = 1'b1;
         mmem_out    = make_line(mmem_addr);
         @(negedge clk);
         mmem_status = 1'b0;
         mmem_out    = {8{$urandom()}};
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic wait_hit();
      int n = 0;
      while (!hit && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("hit_within_bound", 32'(hit), 32'd1);
   endtask

   task automatic do_read(input logic [31:0] a);
      int w = m_lookup(a);
      bit miss = (w < 0);
      if (miss) begin
         m_fill(a);
         fetch_q.push_back(line_of(a));
      end else begin
         m_mru[set_of(a)] = w;
      end
      exp_q.push_back(make_exp(a, miss));
      @(posedge clk); #1;
      addr = a;
      cache_read = 1'b1;
      @(negedge clk);
      if (miss) begin
         chk("miss_hit_low", 32'(hit), 32'd0);
         chk("miss_mmem_r_low", 32'(mmem_r), 32'd0);
         @(negedge clk);
         chk("miss_mmem_r_next", 32'(mmem_r), 32'd1);
      end else begin
         chk("hit_zero_lat", 32'(hit), 32'd1);
      end
      wait_hit();
      @(posedge clk); #1;
      cache_read = 1'b0;
   endtask

   task automatic flush_pulse();
      m_clear();
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   // Flush arriving together with a read in IDLE: no hit that cycle, then a miss.
   task automatic flush_read(input logic [31:0] a);
      m_clear();
      m_fill(a);
      fetch_q.push_back(line_of(a));
      exp_q.push_back(make_exp(a, 1'b1));
      @(posedge clk); #1;
      addr = a;
      cache_read = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_cycle_hit", 32'(hit), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("post_flush_mmem_r", 32'(mmem_r), 32'd0);
      wait_hit();
      @(posedge clk); #1;
      cache_read = 1'b0;
   endtask

   // Flush while the line is being fetched: the fill lands then dies, so the same read fetches again.
   task automatic read_flush_fetch(input logic [31:0] a);
      int n = 0;
      if (m_lookup(a) >= 0) begin
         do_read(a);
         return;
      end
      m_fill(a);
      m_clear();
      m_fill(a);
      fetch_q.push_back(line_of(a));
      fetch_q.push_back(line_of(a));
      exp_q.push_back(make_exp(a, 1'b1));
      @(posedge clk); #1;
      addr = a;
      cache_read = 1'b1;
      @(negedge clk);
      while (!mmem_r && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_started", 32'(mmem_r), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_hit();
      @(posedge clk); #1;
      cache_read = 1'b0;
   endtask

   task automatic reset_mid_fetch(input logic [31:0] a);
      int n = 0;
      if (m_lookup(a) >= 0) flush_pulse();
      resp_hold = 1'b1;
      @(posedge clk); #1;
      addr = a;
      cache_read = 1'b1;
      @(negedge clk);
      while (!mmem_r && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_fetch_started", 32'(mmem_r), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cache_read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      m_reset();
      @(negedge clk);
      chk("rst_mmem_r", 32'(mmem_r), 32'd0);
      chk("rst_mmem_addr", mmem_addr, 32'd0);
      // A stale completion after the abandoned fetch must be ignored.
      mmem_status = 1'b1;
      mmem_out    = make_line(line_of(a));
      @(negedge clk);
      mmem_status = 1'b0;
      chk("stale_status_mmem_r", 32'(mmem_r), 32'd0);
      @(negedge clk);
      chk("stale_status_mmem_r2", 32'(mmem_r), 32'd0);
      resp_hold = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      return a;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b1;
      cache_read  = 1'b0;
      addr        = 32'd0;
      flush       = 1'b0;
      mmem_status = 1'b0;
      mmem_out    = '0;
      resp_hold   = 1'b0;
      fetch_seen  = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_mmem_r", 32'(mmem_r), 32'd0);
      chk("reset_mmem_addr", mmem_addr, 32'd0);
      chk("reset_hit", 32'(hit), 32'd0);
      chk("reset_cache_out", cache_out, 32'd0);

      // Cold miss, second way, zero-latency hits.
      do_read(32'h0000_0004);
      do_read(32'h0000_0100);
      do_read(32'h0000_0004);
      do_read(32'h0000_0100);
      // PLRU: touch 0x4, then 0x200 evicts the 0x100 line.
      do_read(32'h0000_0004);
      do_read(32'h0000_0200);
      do_read(32'h0000_0004);
      do_read(32'h0000_0100);
      // Flush in IDLE.
      flush_pulse();
      do_read(32'h0000_0004);
      flush_read(32'h0000_0004);
      // Flush during fetch.
      read_flush_fetch(32'h0000_0300);
      // Reset mid-fetch, then previous addresses miss.
      do_read(32'h0000_0104);
      reset_mid_fetch(32'h0000_0404);
      do_read(32'h0000_0004);
      do_read(32'h0000_0104);

      for (int i = 0; i < 250; i++) begin
         int r = int'($urandom_range(0, 19));
         if (r == 0)      flush_pulse();
         else if (r == 1) read_flush_fetch(rand_addr());
         else if (r == 2) flush_read(rand_addr());
         else             do_read(rand_addr());
      end

      repeat (4) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
